// File: rtl/spike_event_encoder.sv
// Spike vector FIFO plus IDLE/LOAD/SEND serialiser that emits one AER packet per set bit, lowest index first.
// Build option: define SPIKE_TIMESTAMP_EN to tag each vector with a timestep and expose event_timestep.
module spike_event_encoder #(
  parameter int N_NEURONS  = 16,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TS_W       = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_NEURONS-1:0]        spike_in,
  input  logic                        spike_valid,
  output logic [ADDR_W-1:0]           event_addr,
  output logic                        event_valid,
  input  logic                        event_ready,
  output logic                        busy,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
`ifdef SPIKE_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]             event_timestep
`endif
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (ADDR_W != $clog2(N_NEURONS)) begin : g_bad_addr_w
    $error("ADDR_W must equal log2(N_NEURONS)");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (TS_W < 1) begin : g_bad_ts_w
    $error("TS_W must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [N_NEURONS-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic [N_NEURONS-1:0] r_pending;
  logic                 r_overflow;
  logic                 w_push_req;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_accept;
  logic                 w_last;
  logic [N_NEURONS-1:0] w_pending_cleared;
  logic [ADDR_W-1:0]    w_low_idx;

  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_pop      = (r_state == S_LOAD);
  assign w_push_req = spike_valid && (spike_in != '0);
  // A full FIFO still accepts a vector on the cycle its head is popped.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_accept   = event_valid && event_ready;

  // Clearing the lowest set bit: x & (x - 1).
  assign w_pending_cleared = r_pending & (r_pending - 1'b1);
  assign w_last            = (w_pending_cleared == '0);

  always_comb begin
    w_low_idx = '0;
    for (int i = N_NEURONS - 1; i >= 0; i--) begin
      if (r_pending[i]) w_low_idx = ADDR_W'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= spike_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_push_req && !w_push) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pending <= '0;
    end else if (w_pop) begin
      r_pending <= r_mem[r_rd_ptr];
    end else if (w_accept) begin
      r_pending <= w_pending_cleared;
    end
  end

`ifdef SPIKE_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;
  logic [TS_W-1:0] r_pend_ts;
  logic [TS_W-1:0] r_ts_mem [FIFO_DEPTH];

  always_ff @(posedge clock) begin
    if (w_push) r_ts_mem[r_wr_ptr] <= r_ts;
  end

  // Every strobe advances time, including empty and dropped vectors.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ts      <= '0;
      r_pend_ts <= '0;
    end else begin
      if (spike_valid) r_ts <= r_ts + 1'b1;
      if (w_pop)       r_pend_ts <= r_ts_mem[r_rd_ptr];
    end
  end

  assign event_timestep = r_pend_ts;
`endif

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (!w_empty) w_state_next = S_LOAD;
      S_LOAD:  w_state_next = S_SEND;
      S_SEND:  if (w_accept && w_last) w_state_next = w_empty ? S_IDLE : S_LOAD;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    event_valid = (r_state == S_SEND);
    busy        = (r_state != S_IDLE) || !w_empty;
  end

  assign event_addr = w_low_idx;
  assign overflow   = r_overflow;
  assign fifo_count = r_count;

endmodule
